// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-memory controller: FSM states, access size,
// wait-counter width and the access fault rule.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        SZ_WORD = 1'b0,
        SZ_BYTE = 1'b1
    } access_size_e;

    localparam int WAIT_CNT_W = 4;

    // Word accesses must be lane-0 aligned; any access beyond the implemented depth faults.
    function automatic logic access_fault(
        input access_size_e size,
        input logic [1:0]   lane,
        input logic [31:0]  word_idx,
        input logic [31:0]  depth
    );
        return ((size == SZ_WORD) && (lane != 2'b00)) || (word_idx >= depth);
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane helper: merges a store byte into a word and extracts a zero-extended load byte.
// Purely combinational, no latency, no backpressure.
module mem_byte_lane #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word_i,
    input  logic [1:0]        lane_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] merged_o,
    output logic [DATA_W-1:0] byte_zx_o
);

    localparam int LANES = DATA_W / 8;

    always_comb begin
        merged_o  = word_i;
        byte_zx_o = '0;
        for (int l = 0; l < LANES; l++) begin
            if (int'(lane_i) == l) begin
                merged_o[l*8 +: 8]  = byte_i;
                byte_zx_o[7:0]      = word_i[l*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: word/byte load-store with programmable wait states and fault flagging.
// Latency: ready_o one cycle after the edge WAIT_CYCLES past accept; throughput one access per WAIT_CYCLES+1.
// Backpressure: requests are ignored while in WAIT. DATA_MEM_DBG_PORT_EN adds a combinational debug read port.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_i,
    input  logic              we_i,
    input  logic              byte_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              fault_o,
    output logic              busy_o
`ifdef DATA_MEM_DBG_PORT_EN
    ,
    input  logic [ADDR_W-3:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_rdata_o
`endif
);

    localparam int IDX_W   = ADDR_W - 2;
    localparam int MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  we_q, we_d;
    access_size_e          size_q, size_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  ready_q, ready_d;
    logic                  fault_q, fault_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;

    logic                  accept;
    logic                  enter_resp;

    logic                  acc_we;
    access_size_e          acc_size;
    logic [ADDR_W-1:0]     acc_addr;
    logic [DATA_W-1:0]     acc_wdata;
    logic [IDX_W-1:0]      acc_idx;
    logic [1:0]            acc_lane;
    logic                  acc_fault;
    logic [MEM_AW-1:0]     mem_idx;
    logic [DATA_W-1:0]     mem_word;
    logic [DATA_W-1:0]     merged_word;
    logic [DATA_W-1:0]     load_byte;
    logic                  mem_we;

    logic [DATA_W-1:0]     mem [DEPTH];

    // With no wait states the access resolves on the accepting edge, so it uses the live request.
    assign acc_we    = NO_WAIT ? we_i : we_q;
    assign acc_size  = NO_WAIT ? (byte_i ? SZ_BYTE : SZ_WORD) : size_q;
    assign acc_addr  = NO_WAIT ? addr_i : addr_q;
    assign acc_wdata = NO_WAIT ? wdata_i : wdata_q;

    assign acc_idx   = acc_addr[ADDR_W-1:2];
    assign acc_lane  = acc_addr[1:0];
    assign acc_fault = access_fault(acc_size, acc_lane, 32'(acc_idx), 32'(DEPTH));
    assign mem_idx   = acc_addr[MEM_AW+1:2];
    assign mem_word  = mem[mem_idx];

    mem_byte_lane #(
        .DATA_W (DATA_W)
    ) u_lane (
        .word_i    (mem_word),
        .lane_i    (acc_lane),
        .byte_i    (acc_wdata[7:0]),
        .merged_o  (merged_word),
        .byte_zx_o (load_byte)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_WORD;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        accept     = req_i && ((state_q == IDLE) || (state_q == RESP));
        enter_resp = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    state_d    = NO_WAIT ? RESP : WAIT;
                    cnt_d      = CNT_LOAD;
                    enter_resp = NO_WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy_o  = (state_q != IDLE);
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            we_d    = we_i;
            size_d  = byte_i ? SZ_BYTE : SZ_WORD;
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end

        ready_d = enter_resp;
        fault_d = fault_q;
        rdata_d = rdata_q;
        if (enter_resp) begin
            fault_d = acc_fault;
            if (acc_fault) begin
                rdata_d = '0;
            end else if (!acc_we) begin
                rdata_d = (acc_size == SZ_BYTE) ? load_byte : mem_word;
            end
        end

        // Reset gating keeps a zero-wait access from committing while reset is held.
        mem_we = enter_resp && acc_we && !acc_fault && reset;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= (acc_size == SZ_BYTE) ? merged_word : acc_wdata;
        end
    end

    assign ready_o = ready_q;
    assign rdata_o = rdata_q;
    assign fault_o = fault_q;

`ifdef DATA_MEM_DBG_PORT_EN
    logic [MEM_AW-1:0] dbg_idx;
    assign dbg_idx     = dbg_addr_i[MEM_AW-1:0];
    assign dbg_rdata_o = (32'(dbg_addr_i) >= 32'(DEPTH)) ? '0 : mem[dbg_idx];
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl: one instance with one wait state, one with none,
// both with a 63-word array, checked against a word-array reference model.
module tb_data_mem_ctrl;

    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int DEP = 63;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          a_req, a_we, a_byte, a_ready, a_fault, a_busy;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_byte, b_ready, b_fault, b_busy;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
`ifdef DATA_MEM_DBG_PORT_EN
    logic [AW-3:0] a_dbg_addr, b_dbg_addr;
    logic [DW-1:0] a_dbg_rdata, b_dbg_rdata;
`endif

    data_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .WAIT_CYCLES(1)) u_dut_a (
        .clk(clk), .reset(reset), .req_i(a_req), .we_i(a_we), .byte_i(a_byte),
        .addr_i(a_addr), .wdata_i(a_wdata), .ready_o(a_ready), .rdata_o(a_rdata),
        .fault_o(a_fault), .busy_o(a_busy)
`ifdef DATA_MEM_DBG_PORT_EN
        , .dbg_addr_i(a_dbg_addr), .dbg_rdata_o(a_dbg_rdata)
`endif
    );

    data_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .WAIT_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(reset), .req_i(b_req), .we_i(b_we), .byte_i(b_byte),
        .addr_i(b_addr), .wdata_i(b_wdata), .ready_o(b_ready), .rdata_o(b_rdata),
        .fault_o(b_fault), .busy_o(b_busy)
`ifdef DATA_MEM_DBG_PORT_EN
        , .dbg_addr_i(b_dbg_addr), .dbg_rdata_o(b_dbg_rdata)
`endif
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] ref_mem [2][64];
    logic [31:0] last_rd [2];
    bit          rd_known [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: memory as an array of words, byte lanes handled with shifts and masks.
    task automatic model(input int inst, input bit we, input bit byt, input logic [7:0] addr,
                         input logic [31:0] wd, output bit ef, output logic [31:0] er,
                         output bit check_rd);
        int idx;
        int lane;
        idx  = int'(addr) / 4;
        lane = int'(addr) % 4;
        ef   = (!byt && lane != 0) || (idx >= DEP);
        er   = last_rd[inst];
        check_rd = 1'b0;
        if (ef) begin
            if (we) begin
                rd_known[inst] = 1'b0;
            end else begin
                er = 32'h0;
                last_rd[inst]  = er;
                rd_known[inst] = 1'b1;
                check_rd = 1'b1;
            end
        end else if (we) begin
            if (byt)
                ref_mem[inst][idx] = (ref_mem[inst][idx] & ~(32'hFF << (8 * lane)))
                                   | ({24'h0, wd[7:0]} << (8 * lane));
            else
                ref_mem[inst][idx] = wd;
            check_rd = rd_known[inst];
        end else begin
            er = byt ? ((ref_mem[inst][idx] >> (8 * lane)) & 32'hFF) : ref_mem[inst][idx];
            last_rd[inst]  = er;
            rd_known[inst] = 1'b1;
            check_rd = 1'b1;
        end
    endtask

    // One access on the one-wait-state instance; 'poke' raises a competing store while in WAIT.
    task automatic acc_a(input bit we, input bit byt, input logic [7:0] addr,
                         input logic [31:0] wd, input bit poke);
        bit          ef, crd;
        logic [31:0] er;
        int          lat;
        model(0, we, byt, addr, wd, ef, er, crd);
        a_we = we; a_byte = byt; a_addr = addr; a_wdata = wd; a_req = 1'b1;
        @(negedge clk);
        a_req = 1'b0;
        lat = 1;
        if (poke) begin
            a_req = 1'b1; a_we = 1'b1; a_byte = 1'b0; a_addr = 8'h04; a_wdata = 32'hFFFF_FFFF;
        end
        while (!a_ready && lat < 20) begin
            @(negedge clk);
            a_req = 1'b0;
            lat++;
        end
        a_req = 1'b0;
        chk("a_latency", 32'(lat), 32'd2);
        chk("a_fault", 32'(a_fault), 32'(ef));
        if (crd) chk("a_rdata", a_rdata, er);
        @(negedge clk);
        chk("a_ready_pulse", 32'(a_ready), 32'd0);
        chk("a_busy_idle", 32'(a_busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          we, byt, ef, crd;
        logic [7:0]  ad;
        logic [31:0] wd, er;

        a_req = 0; a_we = 0; a_byte = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_byte = 0; b_addr = '0; b_wdata = '0;
`ifdef DATA_MEM_DBG_PORT_EN
        a_dbg_addr = '0; b_dbg_addr = '0;
`endif
        last_rd[0] = '0; last_rd[1] = '0;
        rd_known[0] = 1'b1; rd_known[1] = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_a_ready", 32'(a_ready), 0); chk("rst_a_busy", 32'(a_busy), 0);
        chk("rst_a_fault", 32'(a_fault), 0); chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_ready", 32'(b_ready), 0); chk("rst_b_busy", 32'(b_busy), 0);
        chk("rst_b_fault", 32'(b_fault), 0); chk("rst_b_rdata", b_rdata, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < DEP; i++) acc_a(1'b1, 1'b0, 8'(i * 4), $urandom, 1'b0);

        acc_a(1'b1, 1'b0, 8'h04, 32'h1234_5678, 1'b0);
        acc_a(1'b0, 1'b0, 8'h04, 32'h0, 1'b0);
        chk("ldr_04", a_rdata, 32'h1234_5678);

        acc_a(1'b1, 1'b1, 8'h05, 32'h0000_00AA, 1'b0);
        acc_a(1'b0, 1'b0, 8'h04, 32'h0, 1'b0);
        chk("ldr_after_strb", a_rdata, 32'h1234_AA78);
        acc_a(1'b0, 1'b1, 8'h07, 32'h0, 1'b0);
        chk("ldrb_07", a_rdata, 32'h0000_0012);

        acc_a(1'b0, 1'b0, 8'h06, 32'h0, 1'b0);
        chk("misaligned_fault", 32'(a_fault), 1);
        chk("misaligned_rdata", a_rdata, 0);
        acc_a(1'b1, 1'b0, 8'hFC, $urandom, 1'b0);
        chk("range_fault", 32'(a_fault), 1);
        acc_a(1'b0, 1'b0, 8'hF8, 32'h0, 1'b0);

        acc_a(1'b0, 1'b0, 8'h20, 32'h0, 1'b1);
        acc_a(1'b0, 1'b0, 8'h04, 32'h0, 1'b0);
        chk("wait_req_ignored", a_rdata, 32'h1234_AA78);

        // Reset during WAIT of a store: store is dropped, outputs clear immediately.
        a_we = 1'b1; a_byte = 1'b0; a_addr = 8'h10; a_wdata = 32'hDEAD_BEEF; a_req = 1'b1;
        @(negedge clk);
        a_req = 1'b0;
        chk("busy_in_wait", 32'(a_busy), 1);
        reset = 1'b0;
        #1;
        chk("midrst_ready", 32'(a_ready), 0); chk("midrst_busy", 32'(a_busy), 0);
        chk("midrst_fault", 32'(a_fault), 0); chk("midrst_rdata", a_rdata, 0);
        @(negedge clk);
        reset = 1'b1;
        last_rd[0] = '0; rd_known[0] = 1'b1;
        @(negedge clk);
        acc_a(1'b0, 1'b0, 8'h10, 32'h0, 1'b0);

        repeat (150) begin
            acc_a(1'($urandom), 1'($urandom), 8'($urandom_range(0, 255)), $urandom,
                  ($urandom_range(0, 7) == 0));
        end

`ifdef DATA_MEM_DBG_PORT_EN
        acc_a(1'b1, 1'b0, 8'h08, 32'hCAFE_F00D, 1'b0);
        a_dbg_addr = 6'd2;
        #1;
        chk("dbg_read", a_dbg_rdata, 32'hCAFE_F00D);
        a_dbg_addr = 6'd63;
        #1;
        chk("dbg_out_of_range", a_dbg_rdata, 32'h0);
`endif

        // Zero-wait instance, req held high: one response per cycle, in order.
        for (int k = 0; k < 140; k++) begin
            wd = $urandom;
            if (k < DEP) begin
                we = 1'b1; byt = 1'b0; ad = 8'(k * 4);
            end else begin
                we = 1'($urandom); byt = 1'($urandom); ad = 8'($urandom_range(0, 255));
            end
            model(1, we, byt, ad, wd, ef, er, crd);
            b_we = we; b_byte = byt; b_addr = ad; b_wdata = wd; b_req = 1'b1;
            @(negedge clk);
            chk("b_ready", 32'(b_ready), 1);
            chk("b_fault", 32'(b_fault), 32'(ef));
            if (crd) chk("b_rdata", b_rdata, er);
        end
        b_req = 1'b0;
        @(negedge clk);
        chk("b_ready_end", 32'(b_ready), 0);
        chk("b_busy_end", 32'(b_busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
